mmu_arbiter: RTL and testbench
==============================

Name: mmu_arbiter

Overview:
- Shares the single MMU port between the instruction-fetch requester (ifu_*) and the memory stage (mem_*).
- Each requester sees an MMU-like interface: addr, data out, one-cycle opt pulse, busy, read data.
- Fixed priority to the memory stage, with a starvation guard for fetch.
- Latches one-cycle requests, issues each to the MMU as a one-cycle opt pulse, waits for MMU completion, then returns read data to the winner.

Parameters:
STARVE_LIMIT, 4, max consecutive mem grants while a fetch is pending; 0 = pure mem priority, no guard
(widths from mem_opt.vh: `MEM_OPT_WIDTH, `MEM_OPT_NONE)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
ifu_addr  in  32  fetch address
ifu_data_out  in  32  fetch write data (normally unused)
ifu_opt  in  `MEM_OPT_WIDTH  fetch request; non-NONE for one cycle = request
ifu_data_in  out  32  read data returned to fetch
ifu_busy  out  1  fetch request outstanding
mem_addr  in  32  mem-stage address
mem_data_out  in  32  mem-stage write data
mem_opt  in  `MEM_OPT_WIDTH  mem-stage request pulse
mem_data_in  out  32  read data returned to mem stage
mem_busy  out  1  mem-stage request outstanding
mmu_addr  out  32  to MMU
mmu_data_out  out  32  to MMU
mmu_opt  out  `MEM_OPT_WIDTH  to MMU; non-NONE for exactly one cycle per access
mmu_data_in  in  32  from MMU
mmu_busy  in  1  from MMU; high no later than the cycle after opt, low when done

Behaviour:
- Reset (rst low, async):
  - state IDLE, both pending flags 0, starve counter 0.
  - mmu_opt NONE; mmu_addr, mmu_data_out, ifu_data_in, mem_data_in = 0; ifu_busy, mem_busy = 0.
  - Any in-flight MMU access is abandoned; no data is returned.
- Request capture, per port, every posedge:
  - If opt != NONE and port busy = 0, latch addr/data/opt into that port's slot, set pending and busy.
  - opt != NONE while busy = 1 is a protocol violation: ignored, slot unchanged.
- Busy timing: busy is registered; high from the capturing edge through the completion edge, cleared at completion. A requester pulsing opt on negedge sees busy = 1 at the next negedge.
- Grant selection, in IDLE, over pending slots plus same-edge captures:
  - Only one candidate: grant it.
  - Both: grant mem unless STARVE_LIMIT != 0 and counter == STARVE_LIMIT; then grant ifu.
- Starve counter:
  - Increments on each mem grant made while ifu is pending.
  - Clears on an ifu grant, or on any edge where ifu is not pending.
  - Saturates at STARVE_LIMIT.
- FSM (2-bit state, plus 1-bit grant_id):
  - IDLE: if a candidate exists, drive mmu_addr/mmu_data_out/mmu_opt from the granted slot, record grant_id → ISSUE. A request captured on this edge may be issued on the same edge (bypass).
  - ISSUE: mmu_opt <= NONE → WAIT.
  - WAIT: on an edge with mmu_busy = 0:
    - copy mmu_data_in into grant_id's data_in register;
    - clear that port's pending and busy → IDLE.
  - Illegal state → IDLE.
- Minimum latency (MMU never busy):
  - Capture/issue at edge 0; ISSUE at edge 1; completion at edge 2.
  - busy falls after edge 2, with data valid at the same time.
- Data return:
  - xxx_data_in holds its value until that port's next completion; it is written on writes too.
  - The non-granted port's data_in never changes.
- Other port: may capture a request while the granted one is in flight; it is served on the next IDLE edge. Back-to-back accesses are therefore 3 cycles apart, minimum.
- mmu_addr/mmu_data_out hold their last issued values between accesses.

Decomposition:
- mem_opt.vh supplies `MEM_OPT_WIDTH and `MEM_OPT_NONE.
- Add to common.vh:
  - `MMU_ARB_IDLE/ISSUE/WAIT state codes;
  - `ARB_PORT_IFU = 0, `ARB_PORT_MEM = 1.
- One sub-module is natural: mmu_arb_req_slot, instantiated twice. It holds the capture latch (addr, data, opt, pending, busy) plus the data_in return register.

Test Plan:
- Single mem read at 0x80000010, MMU returns 0xDEADBEEF with busy 3 cycles → mmu_opt pulsed 1 cycle with addr 0x80000010; mem_busy 1 until completion; mem_data_in = 0xDEADBEEF; ifu signals untouched.
- ifu and mem pulse on the same edge → mem issued first, ifu issued on the IDLE edge after mem completes; both data values returned to the correct ports.
- STARVE_LIMIT = 2, mem re-requests immediately after each completion, ifu pending throughout → grant order mem, mem, ifu, mem, mem, ifu.
- Second mem_opt pulse while mem_busy = 1 → ignored; exactly one mmu_opt pulse.
- rst low during WAIT → busy flags 0, mmu_opt NONE, data_in 0 immediately (async). After release, a new ifu request completes normally.
- MMU never busy, alternating single requests → each access completes 2 edges after capture; mmu_opt is never high on consecutive cycles.

Source files
------------

// File: rtl/mmu_arbiter_pkg.sv
// Shared types and constants for the MMU port arbiter: request opcode encoding,
// FSM state codes and requester port ids.
package mmu_arbiter_pkg;
  localparam int MEM_OPT_WIDTH = 2;
  localparam logic [MEM_OPT_WIDTH-1:0] MEM_OPT_NONE = '0;

  typedef enum logic [1:0] {
    MMU_ARB_IDLE  = 2'd0,
    MMU_ARB_ISSUE = 2'd1,
    MMU_ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam logic ARB_PORT_IFU = 1'b0;
  localparam logic ARB_PORT_MEM = 1'b1;
endpackage

// File: rtl/mmu_arb_req_slot.sv
// One requester slot: captures a one-cycle request pulse, holds it until the
// arbiter completes it, and keeps the read data returned by that completion.
module mmu_arb_req_slot
  import mmu_arbiter_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_data,
  input  logic [MEM_OPT_WIDTH-1:0] req_opt,
  input  logic                     done,
  input  logic [31:0]              ret_data,
  output logic                     cand,
  output logic [31:0]              sel_addr,
  output logic [31:0]              sel_data,
  output logic [MEM_OPT_WIDTH-1:0] sel_opt,
  output logic                     busy,
  output logic [31:0]              data_in
);
  logic [31:0]              addr_q, addr_d, data_q, data_d, ret_q, ret_d;
  logic [MEM_OPT_WIDTH-1:0] opt_q, opt_d;
  logic                     pend_q, pend_d, busy_q, busy_d, cap;

  // A pulse while busy is a protocol violation and is dropped.
  assign cap = (req_opt != MEM_OPT_NONE) && !busy_q;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    opt_d  = opt_q;
    pend_d = pend_q;
    busy_d = busy_q;
    ret_d  = ret_q;
    if (cap) begin
      addr_d = req_addr;
      data_d = req_data;
      opt_d  = req_opt;
      pend_d = 1'b1;
      busy_d = 1'b1;
    end
    if (done) begin
      pend_d = 1'b0;
      busy_d = 1'b0;
      ret_d  = ret_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      data_q <= '0;
      opt_q  <= MEM_OPT_NONE;
      pend_q <= 1'b0;
      busy_q <= 1'b0;
      ret_q  <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      opt_q  <= opt_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      ret_q  <= ret_d;
    end
  end

  // Same-edge bypass: a request captured this edge can be granted immediately.
  assign cand     = pend_q | cap;
  assign sel_addr = cap ? req_addr : addr_q;
  assign sel_data = cap ? req_data : data_q;
  assign sel_opt  = cap ? req_opt  : opt_q;
  assign busy     = busy_q;
  assign data_in  = ret_q;
endmodule

// File: rtl/mmu_arbiter.sv
// Shares one MMU port between instruction fetch and the memory stage.
// Memory stage has priority; a starvation counter forces a fetch grant.
module mmu_arbiter
  import mmu_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              ifu_addr,
  input  logic [31:0]              ifu_data_out,
  input  logic [MEM_OPT_WIDTH-1:0] ifu_opt,
  output logic [31:0]              ifu_data_in,
  output logic                     ifu_busy,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_data_out,
  input  logic [MEM_OPT_WIDTH-1:0] mem_opt,
  output logic [31:0]              mem_data_in,
  output logic                     mem_busy,
  output logic [31:0]              mmu_addr,
  output logic [31:0]              mmu_data_out,
  output logic [MEM_OPT_WIDTH-1:0] mmu_opt,
  input  logic [31:0]              mmu_data_in,
  input  logic                     mmu_busy
);
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  arb_state_e               state_q, state_d;
  logic                     gid_q, gid_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [31:0]              maddr_q, maddr_d, mdata_q, mdata_d;
  logic [MEM_OPT_WIDTH-1:0] mopt_q, mopt_d;

  logic                     ifu_cand, mem_cand, ifu_done, mem_done, grant_mem, starve;
  logic [31:0]              ifu_sa, ifu_sd, mem_sa, mem_sd;
  logic [MEM_OPT_WIDTH-1:0] ifu_so, mem_so;

  mmu_arb_req_slot u_ifu (
    .clk(clk), .rst(rst), .req_addr(ifu_addr), .req_data(ifu_data_out), .req_opt(ifu_opt),
    .done(ifu_done), .ret_data(mmu_data_in), .cand(ifu_cand), .sel_addr(ifu_sa),
    .sel_data(ifu_sd), .sel_opt(ifu_so), .busy(ifu_busy), .data_in(ifu_data_in)
  );

  mmu_arb_req_slot u_mem (
    .clk(clk), .rst(rst), .req_addr(mem_addr), .req_data(mem_data_out), .req_opt(mem_opt),
    .done(mem_done), .ret_data(mmu_data_in), .cand(mem_cand), .sel_addr(mem_sa),
    .sel_data(mem_sd), .sel_opt(mem_so), .busy(mem_busy), .data_in(mem_data_in)
  );

  assign starve    = (STARVE_LIMIT != 0) && (cnt_q == LIM);
  assign grant_mem = mem_cand && !(ifu_cand && starve);

  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    cnt_d    = cnt_q;
    maddr_d  = maddr_q;
    mdata_d  = mdata_q;
    mopt_d   = MEM_OPT_NONE;
    ifu_done = 1'b0;
    mem_done = 1'b0;
    if (!ifu_cand) cnt_d = '0;
    case (state_q)
      MMU_ARB_IDLE: begin
        if (ifu_cand || mem_cand) begin
          gid_d   = grant_mem ? ARB_PORT_MEM : ARB_PORT_IFU;
          maddr_d = grant_mem ? mem_sa : ifu_sa;
          mdata_d = grant_mem ? mem_sd : ifu_sd;
          mopt_d  = grant_mem ? mem_so : ifu_so;
          state_d = MMU_ARB_ISSUE;
          // Count mem wins that held off a waiting fetch; any fetch win resets.
          if (!grant_mem) cnt_d = '0;
          else if (ifu_cand && cnt_q != LIM) cnt_d = cnt_q + CW'(1);
        end
      end
      MMU_ARB_ISSUE: state_d = MMU_ARB_WAIT;
      MMU_ARB_WAIT: begin
        if (!mmu_busy) begin
          ifu_done = (gid_q == ARB_PORT_IFU);
          mem_done = (gid_q == ARB_PORT_MEM);
          state_d  = MMU_ARB_IDLE;
        end
      end
      default: state_d = MMU_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MMU_ARB_IDLE;
      gid_q   <= ARB_PORT_IFU;
      cnt_q   <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      mopt_q  <= MEM_OPT_NONE;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mopt_q  <= mopt_d;
    end
  end

  assign mmu_addr     = maddr_q;
  assign mmu_data_out = mdata_q;
  assign mmu_opt      = mopt_q;
endmodule

// File: tb/tb_mmu_arbiter.sv
// Directed bench for mmu_arbiter: vector table for single/dual requests plus
// hand sequences for starvation, dropped pulses, async reset and latency.
module tb_mmu_arbiter;
  import mmu_arbiter_pkg::*;

  localparam logic [MEM_OPT_WIDTH-1:0] RD = 2'b01;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [31:0]              ifu_addr = '0, ifu_data_out = '0, mem_addr = '0, mem_data_out = '0;
  logic [MEM_OPT_WIDTH-1:0] ifu_opt = '0, mem_opt = '0;
  logic [31:0]              ifu_data_in, mem_data_in, mmu_addr, mmu_data_out;
  logic [MEM_OPT_WIDTH-1:0] mmu_opt;
  logic                     ifu_busy, mem_busy;
  logic [31:0]              mmu_data_in = '0;
  logic                     mmu_busy = 1'b0;

  mmu_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .ifu_addr(ifu_addr), .ifu_data_out(ifu_data_out), .ifu_opt(ifu_opt),
    .ifu_data_in(ifu_data_in), .ifu_busy(ifu_busy),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_opt(mem_opt),
    .mem_data_in(mem_data_in), .mem_busy(mem_busy),
    .mmu_addr(mmu_addr), .mmu_data_out(mmu_data_out), .mmu_opt(mmu_opt),
    .mmu_data_in(mmu_data_in), .mmu_busy(mmu_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int lat_cfg = 0, rem = 0, consec = 0;
  logic prev_opt = 1'b0;
  logic [31:0] iss_q[$];
  logic [31:0] exp_ifu = '0, exp_mem = '0;

  function automatic logic [31:0] resp(input logic [31:0] a);
    return (a == 32'h8000_0010) ? 32'hDEAD_BEEF : ({a[15:0], a[31:16]} ^ 32'h0F0F_F0F0);
  endfunction

  // MMU model: sees the opt pulse, stays busy lat_cfg cycles, presents data.
  always @(negedge clk) begin
    if (!rst) begin
      rem = 0;
      mmu_busy = 1'b0;
    end else begin
      if (mmu_opt != MEM_OPT_NONE) begin
        iss_q.push_back(mmu_addr);
        if (prev_opt) consec++;
        rem = lat_cfg;
        mmu_data_in = resp(mmu_addr);
      end else if (rem > 0) rem--;
      mmu_busy = (rem > 0);
    end
    prev_opt = (mmu_opt != MEM_OPT_NONE);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive request pulses for one cycle starting at the current negedge.
  task automatic pulse(input logic di, input logic [31:0] ai, input logic dm, input logic [31:0] am);
    if (di) begin ifu_addr = ai; ifu_opt = RD; exp_ifu = resp(ai); end
    if (dm) begin mem_addr = am; mem_opt = RD; exp_mem = resp(am); end
    @(negedge clk);
    ifu_opt = '0;
    mem_opt = '0;
  endtask

  task automatic wait_idle(input string nm, output int cyc);
    cyc = 0;
    while ((ifu_busy || mem_busy) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (ifu_busy || mem_busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout, busy still %b%b required 00", nm, ifu_busy, mem_busy);
    end
  endtask

  typedef struct {
    logic        di;
    logic [31:0] ai;
    logic        dm;
    logic [31:0] am;
    int          lat;
    int          n_iss;
    logic [31:0] first_a;
    logic [31:0] second_a;
  } vec_t;

  vec_t vecs[4];
  int   exp_nib[6];

  initial begin
    int cyc, nri, nrm;
    vecs[0] = '{1'b1, 32'h0000_1000, 1'b0, 32'h0,         0, 1, 32'h0000_1000, 32'h0};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 32'h0000_2000, 2, 1, 32'h0000_2000, 32'h0};
    vecs[2] = '{1'b1, 32'h0000_3000, 1'b1, 32'h0000_4000, 1, 2, 32'h0000_4000, 32'h0000_3000};
    vecs[3] = '{1'b1, 32'h0000_5004, 1'b1, 32'h0000_6008, 0, 2, 32'h0000_6008, 32'h0000_5004};
    exp_nib = '{2, 2, 1, 2, 2, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mmu_opt", 32'(mmu_opt), 32'h0);
    chk("rst_mmu_addr", mmu_addr, 32'h0);
    chk("rst_busy", {30'h0, ifu_busy, mem_busy}, 32'h0);
    chk("rst_data_in", ifu_data_in | mem_data_in, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single mem read, MMU busy 3 cycles
    lat_cfg = 3;
    iss_q.delete();
    mem_data_out = 32'h1122_3344;
    pulse(1'b0, 32'h0, 1'b1, 32'h8000_0010);
    chk("t1_mem_busy", 32'(mem_busy), 32'h1);
    chk("t1_ifu_busy", 32'(ifu_busy), 32'h0);
    chk("t1_opt", 32'(mmu_opt), 32'(RD));
    chk("t1_addr", mmu_addr, 32'h8000_0010);
    chk("t1_wdata", mmu_data_out, 32'h1122_3344);
    @(negedge clk);
    chk("t1_opt_drop", 32'(mmu_opt), 32'h0);
    wait_idle("t1", cyc);
    chk("t1_latency", 32'(cyc + 1), 32'd4);
    chk("t1_mem_data", mem_data_in, 32'hDEAD_BEEF);
    chk("t1_ifu_data", ifu_data_in, 32'h0);
    chk("t1_n_iss", 32'(iss_q.size()), 32'd1);

    // Vector table: single and simultaneous requests
    for (int v = 0; v < 4; v++) begin
      lat_cfg = vecs[v].lat;
      iss_q.delete();
      pulse(vecs[v].di, vecs[v].ai, vecs[v].dm, vecs[v].am);
      wait_idle($sformatf("v%0d", v), cyc);
      chk($sformatf("v%0d_n_iss", v), 32'(iss_q.size()), 32'(vecs[v].n_iss));
      chk($sformatf("v%0d_first", v), (iss_q.size() > 0) ? iss_q[0] : 32'hFFFF_FFFF, vecs[v].first_a);
      if (vecs[v].n_iss > 1)
        chk($sformatf("v%0d_second", v), (iss_q.size() > 1) ? iss_q[1] : 32'hFFFF_FFFF, vecs[v].second_a);
      chk($sformatf("v%0d_ifu_data", v), ifu_data_in, exp_ifu);
      chk($sformatf("v%0d_mem_data", v), mem_data_in, exp_mem);
    end

    // Starvation guard: mem re-requests at once, fetch stays pending
    lat_cfg = 1;
    iss_q.delete();
    nri = 0;
    nrm = 0;
    for (int c = 0; c < 200; c++) begin
      ifu_opt = '0;
      mem_opt = '0;
      if (nri == 2 && nrm == 4 && !ifu_busy && !mem_busy) break;
      if (!mem_busy && nrm < 4) begin
        mem_addr = 32'h2000_0000 + 32'(nrm); mem_opt = RD; exp_mem = resp(mem_addr); nrm++;
      end
      if (!ifu_busy && nri < 2) begin
        ifu_addr = 32'h1000_0000 + 32'(nri); ifu_opt = RD; exp_ifu = resp(ifu_addr); nri++;
      end
      @(negedge clk);
    end
    wait_idle("starve", cyc);
    for (int i = 0; i < 6; i++)
      chk($sformatf("starve_order%0d", i),
          32'((i < iss_q.size()) ? iss_q[i][31:28] : 4'hF), 32'(exp_nib[i]));
    chk("starve_ifu_data", ifu_data_in, exp_ifu);
    chk("starve_mem_data", mem_data_in, exp_mem);

    // Second pulse while busy is dropped
    lat_cfg = 2;
    iss_q.delete();
    pulse(1'b0, 32'h0, 1'b1, 32'h0000_7000);
    mem_addr = 32'h0000_7777;
    mem_opt = RD;
    @(negedge clk);
    mem_opt = '0;
    wait_idle("drop", cyc);
    chk("drop_n_iss", 32'(iss_q.size()), 32'd1);
    chk("drop_mem_data", mem_data_in, resp(32'h0000_7000));

    // Async reset during WAIT
    lat_cfg = 5;
    pulse(1'b1, 32'h0000_9000, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_busy", {30'h0, ifu_busy, mem_busy}, 32'h0);
    chk("arst_opt", 32'(mmu_opt), 32'h0);
    chk("arst_ifu_data", ifu_data_in, 32'h0);
    chk("arst_mem_data", mem_data_in, 32'h0);
    exp_ifu = '0;
    exp_mem = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Zero-latency MMU, alternating single requests
    lat_cfg = 0;
    for (int k = 0; k < 4; k++) begin
      pulse(k[0] == 1'b0, 32'h0000_A000 + 32'(k), k[0] == 1'b1, 32'h0000_B000 + 32'(k));
      wait_idle($sformatf("lat%0d", k), cyc);
      chk($sformatf("lat%0d_cycles", k), 32'(cyc), 32'd2);
      chk($sformatf("lat%0d_ifu_data", k), ifu_data_in, exp_ifu);
      chk($sformatf("lat%0d_mem_data", k), mem_data_in, exp_mem);
    end
    chk("opt_never_consecutive", 32'(consec), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
